run_ctrl: RTL and testbench
===========================

# run_ctrl

Parametrised run-control unit that replaces the fixed clock/mode controller in front of the CPU core. It debounces the board buttons, runs the machine-mode state machine (reset, run, pause, single-step, error, UART programming) and emits a CPU clock-enable rather than a derived clock. It also maintains the cycle counter and the reset/UART-programming reset strobes. It sits between the board pins, the UART programmer and the CPU core, all on one clock domain.

## Interface
- DIV, 4: CPU enable divider; cpu_en_o pulses once every DIV clk_i cycles in RUN (DIV >= 1).
- DEBOUNCE, 20000: cycles a raw button must stay stable before its level is accepted.
- CNT_W, 32: cycle counter width.
- RST_HOLD, 8: cycles cpu_rst_o is held in RESET (>= 1).

- clk_i  in  1  board clock.
- reset_i  in  1  asynchronous, active-high reset.
- btn_rst_i, btn_err_i, btn_pause_i, btn_continue_i, btn_uart_i, btn_step_i  in  1 each  raw buttons, active high.
- exc_code_i  in  4  core exception: 0 none, 1 restart, 2 fatal, 3 break; others ignored.
- set_cnt_i  in  1  clear cycle counter.
- upg_done_i  in  1  UART programmer finished.
- cpu_en_o  out  1  CPU pipeline enable.
- cpu_rst_o  out  1  synchronous reset to CPU core.
- upg_rst_o  out  1  UART programmer reset (low = programming active).
- cycle_cnt_o  out  CNT_W  enabled CPU cycles since last clear.
- mode_o  out  4  0 RESET, 1 RUN, 2 PAUSE, 3 STEP, 4 ERROR, 6 UPG.

## Operation
- Each button: 2-flop synchroniser, then a debounce counter; the accepted level changes only after DEBOUNCE consecutive equal samples. A rising edge of the accepted level gives a one-cycle press.
- Press priority in the same cycle: rst > uart > err > pause > continue > step. At most one transition per cycle. A button press outranks exc_code_i.
- RESET: cpu_rst_o=1, cpu_en_o=1 every cycle, for RST_HOLD cycles, then RUN. rst press re-enters and restarts the hold count.
- RUN: the divider counts DIV-1..0; cpu_en_o=1 on 0. Transitions:
  - pause or exc 3 -> PAUSE.
  - err or exc 2 -> ERROR.
  - exc 1 -> RESET.
  - uart -> UPG.
  - rst -> RESET.
- PAUSE: cpu_en_o=0. continue -> RUN, with the divider reloaded to DIV-1. step -> STEP.
- STEP: exactly one cycle with cpu_en_o=1, then PAUSE.
- ERROR: cpu_en_o=0. Only rst or uart leave.
- UPG: cpu_en_o=0, upg_rst_o=0. upg_done_i -> RESET. rst aborts -> RESET.
- Cycle counter: +1 on each cycle with cpu_en_o=1 outside RESET; wraps modulo 2^CNT_W. set_cnt_i clears it and wins over an increment in the same cycle.

## Timing
- All outputs are registered.
- Reset values: mode_o=0, cpu_rst_o=1, cpu_en_o=0, upg_rst_o=1, cycle_cnt_o=0; divider and debounce state cleared.
- Press latency: raw edge to press pulse is 2 + DEBOUNCE cycles. The press appears on mode_o one cycle later.
- exc_code_i is sampled only in RUN; a transition is visible on mode_o the next cycle.
- upg_done_i: upg_rst_o returns high the next cycle, together with mode_o=0.
- An asynchronous reset_i assertion in any state, including mid-hold, mid-step or mid-UPG, forces the reset values immediately.

## Configuration
- RUN_CTRL_STEP_EN defined: STEP state and btn_step_i are active as described.
- Not defined: btn_step_i is ignored, STEP is unreachable, and step presses in PAUSE have no effect.
- All other behaviour is identical in both builds.

## Structure
- Shared package run_ctrl_pkg holds:
  - the mode encoding as a 4-bit typedef with named constants;
  - the exception code constants (EXC_NONE, EXC_RESTART, EXC_FATAL, EXC_BREAK).
- Sub-module btn_debounce contains the synchroniser, debounce counter and edge detect. It is parametrised by DEBOUNCE and instantiated once per button.

## Test plan
- DEBOUNCE=4, DIV=4, RST_HOLD=3, after reset_i release: cpu_rst_o high 3 cycles, then mode_o=1; cpu_en_o pulses every 4th cycle; cycle_cnt_o=5 after 20 RUN cycles.
- btn_pause_i bouncing 1-0-1 within 3 cycles, then held: exactly one press; mode_o=2; cpu_en_o stays 0; cycle_cnt_o frozen.
- With RUN_CTRL_STEP_EN, PAUSE, three step presses: three single-cycle cpu_en_o pulses, counter +3, mode_o back to 2. Without the macro: no pulses, mode_o stays 2.
- exc_code_i=2 in RUN -> mode_o=4 next cycle. btn_continue_i press: no change. btn_rst_i press -> RESET.
- btn_uart_i press -> mode_o=6, upg_rst_o=0. upg_done_i pulse -> upg_rst_o=1 and mode_o=0 the next cycle.
- CNT_W=4 near 15, with set_cnt_i coinciding with a cpu_en_o pulse -> counter 0. Without set_cnt_i, wraps 15 -> 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: machine-mode encoding and core exception codes shared by run_ctrl
package run_ctrl_pkg;
  typedef enum logic [3:0] {
    MODE_RESET = 4'd0,
    MODE_RUN   = 4'd1,
    MODE_PAUSE = 4'd2,
    MODE_STEP  = 4'd3,
    MODE_ERROR = 4'd4,
    MODE_UPG   = 4'd6
  } mode_t;
  localparam logic [3:0] EXC_NONE    = 4'd0;
  localparam logic [3:0] EXC_RESTART = 4'd1;
  localparam logic [3:0] EXC_FATAL   = 4'd2;
  localparam logic [3:0] EXC_BREAK   = 4'd3;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge press pulse
module btn_debounce import run_ctrl_pkg::*; #(
  parameter int DEBOUNCE = 20000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  logic [1:0] sync;
  logic lvl;
  logic [CW-1:0] cnt;
  logic flip;
  assign flip = sync[1] != lvl && cnt == CNT_MAX;
  // accept a new level after DEBOUNCE consecutive differing samples; pulse on 0->1
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync    <= '0;
      lvl     <= 1'b0;
      cnt     <= '0;
      press_o <= 1'b0;
    end else begin
      sync    <= {sync[0], btn_i};
      lvl     <= lvl ^ flip;
      cnt     <= (sync[1] == lvl || flip) ? '0 : cnt + 1'b1;
      press_o <= flip && sync[1];
    end
  end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: debounced run-control FSM with CPU clock-enable and cycle counter (option: RUN_CTRL_STEP_EN)
module run_ctrl import run_ctrl_pkg::*; #(
  parameter int DIV      = 4,
  parameter int DEBOUNCE = 20000,
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             btn_rst_i,
  input  logic             btn_err_i,
  input  logic             btn_pause_i,
  input  logic             btn_continue_i,
  input  logic             btn_uart_i,
  input  logic             btn_step_i,
  input  logic [3:0]       exc_code_i,
  input  logic             set_cnt_i,
  input  logic             upg_done_i,
  output logic             cpu_en_o,
  output logic             cpu_rst_o,
  output logic             upg_rst_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output mode_t            mode_o
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD - 1);
`ifdef RUN_CTRL_STEP_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif
  logic [5:0] btn, press, act, pick;
  logic [DW-1:0] div, nd;
  logic [HW-1:0] hold, nh;
  mode_t nm;
  assign btn = {btn_step_i, btn_continue_i, btn_pause_i, btn_err_i, btn_uart_i, btn_rst_i};
  for (genvar b = 0; b < 6; b++) begin : g_db
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .btn_i(btn[b]),
      .press_o(press[b])
    );
  end
  assign act  = {press[5] & STEP_EN, press[4:0]};
  assign pick = act & (~act + 6'd1);
  // next mode from the single highest-priority press, then exceptions while running
  always_comb begin
    nm = MODE_RESET;
    case (mode_o)
      MODE_RESET: nm = (pick[0] || hold != HOLD_MAX) ? MODE_RESET : MODE_RUN;
      MODE_RUN:   nm = pick[0] ? MODE_RESET : pick[1] ? MODE_UPG : pick[2] ? MODE_ERROR :
                       pick[3] ? MODE_PAUSE : exc_code_i == EXC_RESTART ? MODE_RESET :
                       exc_code_i == EXC_FATAL ? MODE_ERROR : exc_code_i == EXC_BREAK ? MODE_PAUSE : MODE_RUN;
      MODE_PAUSE: nm = pick[0] ? MODE_RESET : pick[4] ? MODE_RUN : pick[5] ? MODE_STEP : MODE_PAUSE;
      MODE_STEP:  nm = pick[0] ? MODE_RESET : MODE_PAUSE;
      MODE_ERROR: nm = pick[0] ? MODE_RESET : pick[1] ? MODE_UPG : MODE_ERROR;
      MODE_UPG:   nm = (pick[0] || upg_done_i) ? MODE_RESET : MODE_UPG;
      default:    nm = MODE_RESET;
    endcase
    nh = (mode_o == MODE_RESET && nm == MODE_RESET && !pick[0]) ? hold + 1'b1 : '0;
    nd = nm != MODE_RUN ? div : (mode_o != MODE_RUN || div == '0) ? DIV_MAX : div - 1'b1;
  end
  // state plus outputs registered from the next state; counter counts visible enables
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_o      <= MODE_RESET;
      hold        <= '0;
      div         <= '0;
      cpu_en_o    <= 1'b0;
      cpu_rst_o   <= 1'b1;
      upg_rst_o   <= 1'b1;
      cycle_cnt_o <= '0;
    end else begin
      mode_o      <= nm;
      hold        <= nh;
      div         <= nd;
      cpu_en_o    <= nm == MODE_RESET || nm == MODE_STEP || (nm == MODE_RUN && nd == '0);
      cpu_rst_o   <= nm == MODE_RESET;
      upg_rst_o   <= nm != MODE_UPG;
      cycle_cnt_o <= set_cnt_i ? '0 : cycle_cnt_o + CNT_W'(cpu_en_o && mode_o != MODE_RESET);
    end
  end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed stimulus with a cycle-level behavioural model and literal checkpoints
module tb_run_ctrl;
  localparam int D = 4, DV = 4, RH = 3, CW = 4;
`ifdef RUN_CTRL_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif
  logic clk_i = 1'b0, reset_i = 1'b1;
  logic [5:0] btn = '0;
  logic [3:0] exc = '0;
  logic set_cnt = 1'b0, upg_done = 1'b0;
  logic cpu_en, cpu_rst, upg_rst;
  logic [CW-1:0] cnt;
  logic [3:0] mode;
  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int m_mode, m_rc, m_rn, m_cnt;
  bit m_en, m_rst, m_upg;
  bit [5:0] m_pr, m_lvl;
  logic [15:0] hist [6];

  always #5 clk_i = ~clk_i;

  run_ctrl #(.DIV(DV), .DEBOUNCE(D), .CNT_W(CW), .RST_HOLD(RH)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .btn_rst_i(btn[0]), .btn_uart_i(btn[1]), .btn_err_i(btn[2]),
    .btn_pause_i(btn[3]), .btn_continue_i(btn[4]), .btn_step_i(btn[5]),
    .exc_code_i(exc), .set_cnt_i(set_cnt), .upg_done_i(upg_done),
    .cpu_en_o(cpu_en), .cpu_rst_o(cpu_rst), .upg_rst_o(upg_rst),
    .cycle_cnt_o(cnt), .mode_o(mode)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rc = 1; m_rn = 0; m_cnt = 0;
    m_en = 0; m_rst = 1; m_upg = 1; m_pr = '0; m_lvl = '0;
    for (int b = 0; b < 6; b++) hist[b] = '0;
  endtask

  task automatic model_step();
    int sel, nm;
    bit [5:0] pr, np;
    logic [D-1:0] win;
    if (reset_i) begin
      model_reset();
      return;
    end
    pr = m_pr & (STEP_ON ? 6'h3f : 6'h1f);
    sel = -1;
    for (int b = 5; b >= 0; b--) if (pr[b]) sel = b;
    nm = m_mode;
    case (m_mode)
      0: nm = sel == 0 ? 0 : (m_rc == RH ? 1 : 0);
      1: nm = sel == 0 ? 0 : sel == 1 ? 6 : sel == 2 ? 4 : sel == 3 ? 2 :
              exc == 1 ? 0 : exc == 2 ? 4 : exc == 3 ? 2 : 1;
      2: nm = sel == 0 ? 0 : sel == 4 ? 1 : sel == 5 ? 3 : 2;
      3: nm = sel == 0 ? 0 : 2;
      4: nm = sel == 0 ? 0 : sel == 1 ? 6 : 4;
      6: nm = (sel == 0 || upg_done) ? 0 : 6;
      default: nm = 0;
    endcase
    m_cnt = set_cnt ? 0 : (m_cnt + int'(m_en && m_mode != 0)) % (1 << CW);
    m_rc = nm == 0 ? ((m_mode == 0 && sel != 0) ? m_rc + 1 : 1) : 0;
    m_rn = nm == 1 ? (m_mode == 1 ? m_rn + 1 : 1) : 0;
    m_en = nm == 0 || nm == 3 || (nm == 1 && m_rn % DV == 0);
    m_rst = nm == 0;
    m_upg = nm != 6;
    m_mode = nm;
    np = '0;
    for (int b = 0; b < 6; b++) begin
      hist[b] = {hist[b][14:0], btn[b]};
      win = hist[b][D+1:2];
      if (&win && !m_lvl[b]) begin
        m_lvl[b] = 1'b1;
        np[b] = 1'b1;
      end else if (~|win && m_lvl[b]) m_lvl[b] = 1'b0;
    end
    m_pr = np;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
    end
  endtask

  task automatic wait_cnt(int c);
    int n = 0;
    while (!(m_mode == 1 && m_en && m_cnt == c) && n < 200) begin
      tick(1);
      n++;
    end
    chk("wait_cnt_budget", n < 200, 1);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("mode", mode, m_mode);
      chk("cpu_en", cpu_en, m_en);
      chk("cpu_rst", cpu_rst, m_rst);
      chk("upg_rst", upg_rst, m_upg);
      chk("cycle_cnt", cnt, m_cnt);
    end
  end

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_mode", mode, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_upg_rst", upg_rst, 1);
    chk("rst_cnt", cnt, 0);
    reset_i = 1'b0;
    tick(2);
    chk("hold_mode", mode, 0);
    chk("hold_cpu_rst", cpu_rst, 1);
    tick(1);
    chk("run_mode", mode, 1);
    chk("run_cpu_rst", cpu_rst, 0);
    tick(20);
    chk("cnt_after_20", cnt, 5);
    btn[3] = 1; tick(1); btn[3] = 0; tick(1); btn[3] = 1;
    tick(6);
    chk("pause_not_yet", mode, 1);
    tick(1);
    chk("pause_mode", mode, 2);
    chk("pause_cnt", cnt, 7);
    tick(5);
    chk("pause_frozen", cnt, 7);
    chk("pause_en", cpu_en, 0);
    btn[3] = 0; tick(8);
    repeat (3) begin
      btn[5] = 1; tick(7); btn[5] = 0; tick(7);
    end
    chk("step_mode", mode, 2);
    chk("step_cnt", cnt, STEP_ON ? 10 : 7);
    btn[4] = 1; tick(7);
    chk("continue_mode", mode, 1);
    btn[4] = 0; tick(7);
    exc = 2; tick(1); exc = 0;
    chk("fatal_mode", mode, 4);
    btn[4] = 1; tick(7); btn[4] = 0; tick(7);
    chk("error_sticky", mode, 4);
    btn[0] = 1; tick(7);
    chk("err_rst_mode", mode, 0);
    chk("err_rst_cpu_rst", cpu_rst, 1);
    btn[0] = 0; tick(7);
    chk("rerun_mode", mode, 1);
    exc = 3; tick(1); exc = 0;
    chk("break_mode", mode, 2);
    btn[4] = 1; tick(7); btn[4] = 0; tick(7);
    exc = 1; tick(1); exc = 0;
    chk("restart_mode", mode, 0);
    tick(5);
    btn[1] = 1; tick(7);
    chk("upg_mode", mode, 6);
    chk("upg_rst_low", upg_rst, 0);
    btn[1] = 0; tick(7);
    upg_done = 1; tick(1); upg_done = 0;
    chk("upg_done_mode", mode, 0);
    chk("upg_done_rst", upg_rst, 1);
    tick(5);
    wait_cnt(14);
    set_cnt = 1; tick(1); set_cnt = 0;
    chk("set_wins", cnt, 0);
    wait_cnt(15);
    tick(1);
    chk("wrap", cnt, 0);
    btn[1] = 1; tick(7); btn[1] = 0;
    chk("upg_again", mode, 6);
    #2 reset_i = 1'b1;
    model_reset();
    #1;
    chk("async_mode", mode, 0);
    chk("async_upg_rst", upg_rst, 1);
    chk("async_cpu_rst", cpu_rst, 1);
    chk("async_cpu_en", cpu_en, 0);
    chk("async_cnt", cnt, 0);
    tick(2);
    reset_i = 1'b0;
    tick(4);
    chk("post_async_run", mode, 1);
    tick(4);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
